// File: rtl/mult_ctrl.sv
`default_nettype none
// ============================================================================
// mult_ctrl : bus front end for the shift-add multiplier core (operands,
//             init/done handshake, product capture, timeout, status).
// Optional  : define MULT_CTRL_IRQ_EN for the registered interrupt output.
// Revision  : 1.0
// ============================================================================
module mult_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic        wr,
  input  logic        rd,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        mult_init,
  output logic [15:0] mult_op_a,
  output logic [15:0] mult_op_b,
  input  logic        mult_done,
  input  logic [31:0] mult_result,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_RUN   = 2'd2,
    S_CAPT  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_init;
  logic [15:0]      r_op_a;
  logic [15:0]      r_op_b;
  logic [31:0]      r_result;
  logic [31:0]      r_rdata;
  logic             r_busy;
  logic             r_done;
  logic             r_timeout;
  logic [CNT_W-1:0] r_count;
  logic             w_ie;
  logic             w_wr;
  logic             w_rd;
  logic             w_start;
  logic             w_clear;
  logic             w_run_done;
  logic             w_run_tmo;
  logic             w_unused;

  assign w_wr       = sel & wr;
  assign w_rd       = sel & rd;
  assign w_start    = w_wr && (addr == 2'd2) && wdata[0] && (r_state == S_IDLE);
  assign w_clear    = w_wr && (addr == 2'd2) && wdata[1];
  assign w_run_done = (r_state == S_RUN) && mult_done;
  // done takes priority over an expiring timeout in the same cycle
  assign w_run_tmo  = (r_state == S_RUN) && !mult_done && (r_count == c_TMO_LAST);

  assign mult_init = w_init;
  assign mult_op_a = r_op_a;
  assign mult_op_b = r_op_b;
  assign rdata     = r_rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_init      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_DRAIN;
      end
      // the core may still hold done from the previous product
      S_DRAIN: begin
        if (!mult_done) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_init = 1'b1;
        if (mult_done)      w_state_nxt = S_CAPT;
        else if (w_run_tmo) w_state_nxt = S_IDLE;
      end
      S_CAPT: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_op_a  <= 16'h0;
      r_op_b  <= 16'h0;
      r_count <= '0;
    end else begin
      if (w_wr && !r_busy && (addr == 2'd0)) r_op_a <= wdata[15:0];
      if (w_wr && !r_busy && (addr == 2'd1)) r_op_b <= wdata[15:0];
      if (r_state == S_DRAIN) begin
        r_count <= '0;
      end else if ((r_state == S_RUN) && (r_count != c_CNT_MAX)) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_result  <= 32'h0;
    end else begin
      if (w_start) begin
        r_busy    <= 1'b1;
        r_done    <= 1'b0;
        r_timeout <= 1'b0;
      end else begin
        if ((r_state == S_CAPT) || w_run_tmo) r_busy <= 1'b0;
        if (w_run_done)   r_done <= 1'b1;
        else if (w_clear) r_done <= 1'b0;
        if (w_run_tmo)    r_timeout <= 1'b1;
        else if (w_clear) r_timeout <= 1'b0;
      end
      if (w_run_done)     r_result <= mult_result;
      else if (w_run_tmo) r_result <= 32'h0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rdata <= 32'h0;
    end else if (w_rd) begin
      case (addr)
        2'd0:    r_rdata <= {16'h0, r_op_a};
        2'd1:    r_rdata <= {16'h0, r_op_b};
        2'd2:    r_rdata <= {28'h0, w_ie, r_timeout, r_done, r_busy};
        default: r_rdata <= r_result;
      endcase
    end
  end

`ifdef MULT_CTRL_IRQ_EN
  logic r_ie;
  logic r_irq;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ie  <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_wr && (addr == 2'd2)) r_ie <= wdata[2];
      r_irq <= r_ie & (r_done | r_timeout);
    end
  end

  assign w_ie     = r_ie;
  assign irq      = r_irq;
  assign w_unused = &{1'b0, wdata[31:16]};
`else
  assign w_ie     = 1'b0;
  assign irq      = 1'b0;
  assign w_unused = &{1'b0, wdata[31:16], wdata[2]};
`endif

endmodule
`default_nettype wire

// File: tb/tb_mult_ctrl.sv
`default_nettype none
// Self-checking bench for mult_ctrl with a behavioural shift-add core model.
module tb_mult_ctrl;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        sel = 1'b0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        mult_init;
  logic [15:0] mult_op_a;
  logic [15:0] mult_op_b;
  logic        mult_done = 1'b0;
  logic [31:0] mult_result = 32'h0;
  logic        irq;

  int n_pass = 0;
  int n_total = 0;
  int total_init = 0;
  int core_lat = 4;
  bit hold_done = 1'b0;

  mult_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(5)) dut (
    .clk(clk), .resetn(resetn), .sel(sel), .wr(wr), .rd(rd), .addr(addr),
    .wdata(wdata), .rdata(rdata), .mult_init(mult_init), .mult_op_a(mult_op_a),
    .mult_op_b(mult_op_b), .mult_done(mult_done), .mult_result(mult_result), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mult_init) total_init = total_init + 1;

  // Core model: done after core_lat init cycles, held until init drops (or longer if hold_done)
  initial begin : core_model
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!resetn) begin
        mult_done = 1'b0;
        cnt = 0;
      end else if (mult_init) begin
        if (!mult_done) begin
          cnt = cnt + 1;
          if (cnt >= core_lat) begin
            mult_done   = 1'b1;
            mult_result = 32'(mult_op_a) * 32'(mult_op_b);
          end
        end
      end else begin
        cnt = 0;
        if (mult_done && !hold_done) mult_done = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total = n_total + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    sel = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    sel = 1'b1; rd = 1'b1; addr = a;
    @(posedge clk); #1;
    d = rdata;
    sel = 1'b0; rd = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(a, d);
    check(name, d, exp);
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] s;
    int n;
    n = 0;
    do begin
      bus_rd(2'd2, s);
      n = n + 1;
    end while (s[0] && n < 200);
    if (s[0]) check({name, "_busy_timeout"}, s, 32'h0);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          lat;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[5];

  initial begin : main
    int base;
    vecs[0] = '{16'h0003, 16'h0005, 3,  32'h0000000F};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 12, 32'hFFFE0001};
    vecs[2] = '{16'h1234, 16'h0010, 5,  32'h00012340};
    vecs[3] = '{16'h0000, 16'hABCD, 1,  32'h00000000};
    vecs[4] = '{16'h8000, 16'h0002, 15, 32'h00010000};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_init", {31'h0, mult_init}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    resetn = 1'b1;
    @(posedge clk); #1;
    rd_check("rst_op_a", 2'd0, 32'h0);
    rd_check("rst_op_b", 2'd1, 32'h0);
    rd_check("rst_status", 2'd2, 32'h0);
    rd_check("rst_result", 2'd3, 32'h0);

    // table-driven products
    for (int i = 0; i < 5; i++) begin
      core_lat = vecs[i].lat;
      bus_wr(2'd0, {16'hDEAD, vecs[i].a});
      bus_wr(2'd1, {16'hBEEF, vecs[i].b});
      rd_check($sformatf("v%0d_op_a", i), 2'd0, {16'h0, vecs[i].a});
      rd_check($sformatf("v%0d_op_b", i), 2'd1, {16'h0, vecs[i].b});
      base = total_init;
      bus_wr(2'd2, 32'h1);
      rd_check($sformatf("v%0d_busy", i), 2'd2, 32'h1);
      wait_idle($sformatf("v%0d", i));
      rd_check($sformatf("v%0d_status", i), 2'd2, 32'h2);
      rd_check($sformatf("v%0d_result", i), 2'd3, vecs[i].exp);
      check($sformatf("v%0d_init_cycles", i), 32'(total_init - base), 32'(vecs[i].lat));
    end

    // timeout: core never answers
    core_lat = 1000;
    base = total_init;
    bus_wr(2'd2, 32'h1);
    wait_idle("tmo");
    rd_check("tmo_status", 2'd2, 32'h4);
    rd_check("tmo_result", 2'd3, 32'h0);
    check("tmo_init_cycles", 32'(total_init - base), 32'(TMO));
    check("tmo_init_low", {31'h0, mult_init}, 32'h0);
    bus_wr(2'd2, 32'h2);
    rd_check("tmo_cleared", 2'd2, 32'h0);

    // operand writes during busy are ignored
    core_lat = 10;
    bus_wr(2'd0, 32'hFFFF);
    bus_wr(2'd1, 32'hFFFF);
    bus_wr(2'd2, 32'h1);
    bus_wr(2'd0, 32'h0001);
    bus_wr(2'd1, 32'h0002);
    check("busy_op_a_port", {16'h0, mult_op_a}, 32'hFFFF);
    wait_idle("busywr");
    rd_check("busywr_op_a", 2'd0, 32'hFFFF);
    rd_check("busywr_op_b", 2'd1, 32'hFFFF);
    rd_check("busywr_result", 2'd3, 32'hFFFE0001);

    // start + clear in one write: start wins, flags cleared
    core_lat = 2;
    bus_wr(2'd2, 32'h3);
    rd_check("startclr_busy", 2'd2, 32'h1);
    wait_idle("startclr");
    rd_check("startclr_status", 2'd2, 32'h2);

    // back-to-back with done still held: wait in DRAIN
    hold_done = 1'b1;
    bus_wr(2'd0, 32'h2);
    bus_wr(2'd1, 32'h3);
    bus_wr(2'd2, 32'h1);
    wait_idle("drain1");
    rd_check("drain1_result", 2'd3, 32'h6);
    check("drain1_done_held", {31'h0, mult_done}, 32'h1);
    bus_wr(2'd0, 32'h7);
    bus_wr(2'd1, 32'h9);
    base = total_init;
    bus_wr(2'd2, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    rd_check("drain_wait_status", 2'd2, 32'h1);
    check("drain_no_init", 32'(total_init - base), 32'h0);
    hold_done = 1'b0;
    wait_idle("drain2");
    rd_check("drain2_result", 2'd3, 32'h3F);
    check("drain2_init_cycles", 32'(total_init - base), 32'h2);

    // asynchronous reset in the middle of RUN
    core_lat = 12;
    bus_wr(2'd0, 32'h5);
    bus_wr(2'd1, 32'h6);
    bus_wr(2'd2, 32'h1);
    rd_check("mid_busy", 2'd2, 32'h1);
    repeat (3) @(posedge clk);
    #2;
    check("mid_in_run", {31'h0, mult_init}, 32'h1);
    resetn = 1'b0;
    #1;
    check("mid_rst_init", {31'h0, mult_init}, 32'h0);
    check("mid_rst_rdata", rdata, 32'h0);
    check("mid_rst_irq", {31'h0, irq}, 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    rd_check("mid_status", 2'd2, 32'h0);
    rd_check("mid_result", 2'd3, 32'h0);
    rd_check("mid_op_a", 2'd0, 32'h0);
    core_lat = 4;
    bus_wr(2'd0, 32'h7);
    bus_wr(2'd1, 32'h3);
    bus_wr(2'd2, 32'h1);
    wait_idle("post_rst");
    rd_check("post_rst_result", 2'd3, 32'h15);

    // interrupt
    core_lat = 2;
    bus_wr(2'd0, 32'h2);
    bus_wr(2'd1, 32'h2);
    bus_wr(2'd2, 32'h5);
    wait_idle("irq");
    rd_check("irq_result", 2'd3, 32'h4);
`ifdef MULT_CTRL_IRQ_EN
    rd_check("irq_status", 2'd2, 32'hA);
    check("irq_set", {31'h0, irq}, 32'h1);
    bus_wr(2'd2, 32'h2);
    @(posedge clk); #1;
    check("irq_cleared", {31'h0, irq}, 32'h0);
    rd_check("irq_status_clr", 2'd2, 32'h0);
`else
    rd_check("irq_status", 2'd2, 32'h2);
    check("irq_tied_low", {31'h0, irq}, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_ctrl.md
Name: mult_ctrl

Overview:
- Memory-mapped front end that feeds the shift-add multiplier core and consumes its result.
- Sits between the CPU data bus and the multiplier core.
- Holds the 16-bit operands, drives the core's init/done handshake and captures the 32-bit product.
- Exposes busy/done/timeout status and an optional interrupt.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles in RUN waiting for core done before abort
CNT_W, 11, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock
resetn  in  1  reset
sel  in  1  peripheral selected this cycle
wr  in  1  write strobe; qualified by sel
rd  in  1  read strobe; qualified by sel
addr  in  2  word index: 0 OP_A, 1 OP_B, 2 CTRL/STATUS, 3 RESULT
wdata  in  32  write data
rdata  out  32  read data
mult_init  out  1  init to multiplier core
mult_op_a  out  16  operand A to core
mult_op_b  out  16  operand B to core
mult_done  in  1  done from core
mult_result  in  32  product from core
irq  out  1  interrupt request

Behaviour:
- Reset: resetn is asynchronous, active-low. When resetn=0, all registers clear, including mid-operation: state IDLE, op_a=0, op_b=0, result_q=0, busy=0, done_sticky=0, timeout=0, ie=0, count=0, mult_init=0, rdata=0, irq=0.
- Writes (sel&wr), all in one cycle:
  - addr0: op_a<=wdata[15:0].
  - addr1: op_b<=wdata[15:0].
  - addr2: bit0=start, bit1=clear status (done_sticky and timeout <=0), bit2=ie.
  - addr3: ignored.
- Operand writes while busy=1 are ignored. mult_op_a/mult_op_b are driven continuously from op_a/op_b, so they are stable throughout an operation.
- Reads (sel&rd): rdata is registered and valid the cycle after the strobe.
  - addr0: {16'b0,op_a}.
  - addr1: {16'b0,op_b}.
  - addr2: {28'b0,ie,timeout,done_sticky,busy}.
  - addr3: result_q.
- FSM states:
  - IDLE: busy=0, mult_init=0. A start write goes to DRAIN, sets busy=1, clears done_sticky and timeout. A start write while busy is ignored.
  - DRAIN: mult_init=0. Waits for mult_done=0, because the core can still be holding done from the previous product. Then goes to RUN with count<=0.
  - RUN: mult_init=1, count increments each cycle.
    - If mult_done=1: result_q<=mult_result, done_sticky<=1, go to CAPT.
    - Else if count==TIMEOUT_CYCLES-1: timeout<=1, result_q<=0, go to IDLE.
    - If done and timeout coincide, done wins.
  - CAPT: mult_init<=0, busy<=0, go to IDLE. One cycle only.
- If start and clear status are written in the same cycle, start takes precedence and the flags are cleared.
- Latency: start write to busy=0 is 3 + core latency cycles, worst case ~52 for B=0xFFFF.
- result_q holds until the next successful capture or a timeout.
- count saturates and never wraps.

Optional Feature:
- Macro: MULT_CTRL_IRQ_EN.
- Defined: irq is a register set to ie & (done_sticky | timeout). It deasserts the cycle after a clear-status write or ie=0.
- Undefined: irq is tied 0, and the ie bit reads back 0.

Test Plan:
- Write OP_A=0x0003, OP_B=0x0005, CTRL=0x1 -> busy=1; then busy falls, STATUS=0x2, RESULT=0x0000000F, mult_init high only in RUN.
- Write OP_A=0xFFFF, OP_B=0xFFFF, start -> RESULT=0xFFFE0001; an OP_A write during busy leaves op_a=0xFFFF.
- Two back-to-back starts with core done still high -> FSM waits in DRAIN until mult_done=0; second product (7*9) gives RESULT=0x3F.
- Hold mult_done=0 with TIMEOUT_CYCLES=16 -> after 16 RUN cycles STATUS=0x4, RESULT=0, busy=0, mult_init=0.
- Pull resetn low mid-RUN -> immediately mult_init=0, STATUS=0, RESULT=0; after release a new start completes normally.
- With MULT_CTRL_IRQ_EN defined, ie=1, run 2*2 -> irq=1 when done_sticky sets; CTRL=0x2 write -> irq=0 next cycle.
